// File: rtl/trigger_pkg.sv
// Shared constants and types for the inter-board trigger sync transmitter.
package trigger_pkg;

  localparam int unsigned SYN = 0;
  localparam int unsigned TRG = 1;
  localparam int unsigned RSR = 2;
  localparam int unsigned RST = 3;
  localparam int unsigned CAL = 4;

  localparam int unsigned TRIG_W    = 5;
  localparam int unsigned FRAME_LEN = 8;
  localparam int unsigned IDX_W     = $clog2(FRAME_LEN);
  localparam int unsigned SH_W      = FRAME_LEN - 1;
  localparam int unsigned CNT_W     = 16;

  localparam logic START_BIT = 1'b1;
  localparam logic STOP_BIT  = 1'b0;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/trigger_fifo.sv
// Event queue for trigger vectors; push/pop only act on sync-enabled edges,
// and a push into a full queue is accepted when a pop happens on the same edge.
module trigger_fifo
  import trigger_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sync,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [TRIG_W-1:0]            wdata_i,
  output logic [TRIG_W-1:0]            rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(FIFO_DEPTH):0]  level_o,
  output logic [$clog2(FIFO_DEPTH):0]  level_d_c
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [TRIG_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_q;
  logic [AW-1:0]     rd_q;
  logic [LW-1:0]     level_q;
  logic              push_ok_c;
  logic              pop_ok_c;

  assign full_o    = (level_q == LW'(FIFO_DEPTH));
  assign empty_o   = (level_q == '0);
  assign pop_ok_c  = sync && pop_i && !empty_o;
  assign push_ok_c = sync && push_i && (!full_o || pop_ok_c);
  assign level_d_c = level_q + LW'(push_ok_c) - LW'(pop_ok_c);
  assign rdata_o   = mem_q[rd_q];
  assign level_o   = level_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok_c) wr_q <= wr_q + AW'(1);
      if (pop_ok_c)  rd_q <= rd_q + AW'(1);
      level_q <= level_d_c;
    end
  end

  // Storage needs no reset: pointers and level define validity.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/trigger_sync_tx.sv
// Serial transmitter for the trigger sync link: queues non-zero trigger vectors
// and sends each as an 8-bit frame (start, d0..d4, odd parity, stop).
module trigger_sync_tx
  import trigger_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         sync,
  input  logic                         enable,
  input  logic [TRIG_W-1:0]            trig_in,
  output logic                         tx_out,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overflow,
  input  logic                         clr_overflow,
  output logic [CNT_W-1:0]             frame_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  tx_state_e              state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [SH_W-1:0]        sh_q, sh_d;
  logic                   tx_q, tx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   busy_q, busy_d;
  logic                   ovf_q;

  logic                   push_req_c;
  logic                   load_c;
  logic                   drop_c;
  logic                   full;
  logic                   empty;
  logic [TRIG_W-1:0]      head;
  logic [$clog2(FIFO_DEPTH):0] level_d;

  assign push_req_c = enable && (trig_in != '0);
  assign drop_c     = sync && push_req_c && full && !load_c;

  trigger_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .sync      (sync),
    .push_i    (push_req_c),
    .pop_i     (load_c),
    .wdata_i   (trig_in),
    .rdata_o   (head),
    .full_o    (full),
    .empty_o   (empty),
    .level_o   (fifo_level),
    .level_d_c (level_d)
  );

  // Serializer: start bit is driven on the pop edge, remaining 7 bits shift out LSB first.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    load_c  = 1'b0;
    if (sync) begin
      case (state_q)
        IDLE: begin
          tx_d   = 1'b0;
          load_c = !empty;
        end
        SEND: begin
          if (idx_q != LAST_IDX) begin
            tx_d  = sh_q[0];
            sh_d  = {1'b0, sh_q[SH_W-1:1]};
            idx_d = idx_q + IDX_W'(1);
          end else if (!empty) begin
            load_c = 1'b1;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b0;
          end
        end
      endcase
      if (load_c) begin
        state_d = SEND;
        idx_d   = '0;
        tx_d    = START_BIT;
        sh_d    = {STOP_BIT, ~^head, head};
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
    busy_d = (state_d == SEND) || (level_d != '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      // Clear acts on every edge, but a drop on the same edge wins.
      if (drop_c)            ovf_q <= 1'b1;
      else if (clr_overflow) ovf_q <= 1'b0;
    end
  end

  assign tx_out    = tx_q;
  assign busy      = busy_q;
  assign overflow  = ovf_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_trigger_sync_tx.sv
// Randomized and directed bench for trigger_sync_tx against a queue-based frame model.
module tb_trigger_sync_tx;
  import trigger_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     reset = 1'b0;
  logic                     sync = 1'b0;
  logic                     enable = 1'b0;
  logic [TRIG_W-1:0]        trig_in = '0;
  logic                     clr_overflow = 1'b0;
  logic                     tx_out;
  logic                     busy;
  logic [$clog2(DEPTH):0]   fifo_level;
  logic                     overflow;
  logic [15:0]              frame_cnt;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int sync_div = 1;
  bit rand_sync = 1'b0;
  bit chk_en = 1'b0;

  trigger_sync_tx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .sync         (sync),
    .enable       (enable),
    .trig_in      (trig_in),
    .tx_out       (tx_out),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow),
    .frame_cnt    (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: event queue plus position inside the current frame.
  logic [TRIG_W-1:0] mq[$];
  int                m_pos = -1;
  logic [TRIG_W-1:0] m_vec = '0;
  logic              m_tx = 1'b0;
  logic [15:0]       m_cnt = '0;
  logic              m_ovf = 1'b0;
  logic              m_busy = 1'b0;

  function automatic logic frame_bit(input logic [TRIG_W-1:0] v, input int k);
    if (k == 0) return 1'b1;
    if (k <= 5) return v[k-1];
    if (k == 6) return ~^v;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    bit do_pop;
    bit drop;
    logic [TRIG_W-1:0] popv;
    if (reset) begin
      mq.delete();
      m_pos = -1; m_tx = 1'b0; m_cnt = '0; m_ovf = 1'b0; m_busy = 1'b0;
    end else begin
      drop = 1'b0;
      popv = '0;
      if (sync) begin
        do_pop = (m_pos < 0 || m_pos == 7) && mq.size() > 0;
        if (do_pop) popv = mq.pop_front();
        if (enable && trig_in != '0) begin
          if (mq.size() < DEPTH) mq.push_back(trig_in);
          else drop = 1'b1;
        end
        if (do_pop) begin
          m_vec = popv; m_pos = 0; m_cnt = m_cnt + 16'd1;
        end else if (m_pos >= 0 && m_pos < 7) m_pos++;
        else m_pos = -1;
        m_tx = (m_pos < 0) ? 1'b0 : frame_bit(m_vec, m_pos);
      end
      if (drop) m_ovf = 1'b1;
      else if (clr_overflow) m_ovf = 1'b0;
      m_busy = (m_pos >= 0) || (mq.size() != 0);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_tx", 32'(tx_out), 32'(m_tx));
      check("m_busy", 32'(busy), 32'(m_busy));
      check("m_level", 32'(fifo_level), 32'(mq.size()));
      check("m_ovf", 32'(overflow), 32'(m_ovf));
      check("m_cnt", 32'(frame_cnt), 32'(m_cnt));
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
    if (rand_sync) sync = 1'($urandom_range(0, 1));
    else sync = ((cyc % sync_div) == 0);
  endtask

  task automatic do_reset();
    step(); reset = 1'b1; trig_in = '0; enable = 1'b1; clr_overflow = 1'b0;
    step(); reset = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin step(); n++; end
    check(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    logic [7:0] seq;
    logic [TRIG_W-1:0] v;
    int mx;

    do_reset();
    chk_en = 1'b1;
    check("rst_tx", 32'(tx_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_cnt", 32'(frame_cnt), 32'd0);

    // Single TRG frame with sync always high.
    step(); trig_in = TRIG_W'(1) << TRG;
    step(); trig_in = '0;
    seq = '0;
    for (int i = 0; i < 8; i++) begin step(); seq = {seq[6:0], tx_out}; end
    check("single_seq", 32'(seq), 32'hA0);
    check("single_cnt", 32'(frame_cnt), 32'd1);
    check("single_busy_stop", 32'(busy), 32'd1);
    step();
    check("single_busy_after", 32'(busy), 32'd0);

    // sync every 4th cycle; a vector present only on a non-sync edge is not captured.
    do_reset();
    sync_div = 4;
    step(); trig_in = (TRIG_W'(1) << CAL) | (TRIG_W'(1) << SYN);
    for (int i = 0; i < 3; i++) step();
    trig_in = '0;
    while (sync) step();
    trig_in = TRIG_W'(1) << RSR;
    step(); trig_in = '0;
    wait_idle(200, "div4_idle");
    check("div4_cnt", 32'(frame_cnt), 32'd1);
    sync_div = 1;

    // Burst of 6 into a depth-4 queue: one dropped.
    do_reset();
    for (int i = 1; i <= 6; i++) begin step(); trig_in = TRIG_W'(i); end
    step(); trig_in = '0;
    check("burst_ovf", 32'(overflow), 32'd1);
    check("burst_level", 32'(fifo_level), 32'd4);
    wait_idle(100, "burst_idle");
    check("burst_cnt", 32'(frame_cnt), 32'd5);
    step(); clr_overflow = 1'b1;
    step(); clr_overflow = 1'b0;
    check("burst_clr", 32'(overflow), 32'd0);

    // Push into a full queue on the same edge as the stop-bit pop.
    do_reset();
    for (int i = 1; i <= 5; i++) begin step(); trig_in = TRIG_W'(i + 8); end
    for (int i = 0; i < 4; i++) begin step(); trig_in = '0; end
    step(); trig_in = TRIG_W'(20);
    step(); trig_in = '0;
    check("fullpop_level", 32'(fifo_level), 32'd4);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    wait_idle(100, "fullpop_idle");

    // Reset when bit 3 would be driven, then a clean frame.
    do_reset();
    step(); trig_in = TRIG_W'(1) << CAL;
    step(); trig_in = '0;
    step(); step();
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    check("midrst_tx", 32'(tx_out), 32'd0);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_cnt", 32'(frame_cnt), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    trig_in = (TRIG_W'(1) << SYN) | (TRIG_W'(1) << TRG) | (TRIG_W'(1) << RSR);
    step(); trig_in = '0;
    seq = '0;
    for (int i = 0; i < 8; i++) begin step(); seq = {seq[6:0], tx_out}; end
    check("midrst_seq", 32'(seq), 32'hF0);
    check("midrst_cnt2", 32'(frame_cnt), 32'd1);

    // Disable with two events queued: both still drain, new input ignored.
    do_reset();
    for (int i = 0; i < 3; i++) begin step(); trig_in = TRIG_W'(1) << (RST - i); end
    step(); enable = 1'b0;
    mx = 0;
    for (int i = 0; i < 30; i++) begin
      trig_in = TRIG_W'($urandom_range(1, 31));
      if (int'(fifo_level) > mx) mx = int'(fifo_level);
      step();
    end
    trig_in = '0;
    check("dis_maxlvl", 32'(mx), 32'd2);
    wait_idle(100, "dis_idle");
    check("dis_cnt", 32'(frame_cnt), 32'd3);

    // Randomized traffic against the model.
    do_reset();
    rand_sync = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      enable = ($urandom_range(0, 9) < 8);
      v = TRIG_W'($urandom_range(1, 31));
      trig_in = ($urandom_range(0, 9) < 5) ? v : '0;
      clr_overflow = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 199) == 0);
    end
    rand_sync = 1'b0;
    step(); reset = 1'b0; trig_in = '0; clr_overflow = 1'b0;
    wait_idle(200, "rand_idle");
    step();

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
